// File: rtl/state_machine_fp.sv
// ---------------------------------------------------------------------------
// state_machine_fp
// Single-precision IEEE-754 add/sub/mul sequencer driven by a UART command
// word. Each command runs through a fixed multi-cycle FSM:
// IDLE -> LOAD -> ALIGN -> EXECUTE -> NORMALIZE -> ROUND -> DONE.
// Rounding is round-to-nearest-even.
//
// Ports
//   clk      in   1   system clock, rising edge
//   reset    in   1   asynchronous active-low reset
//   uart_in  in   66  {B[31:0], A[31:0], opcode[1:0]}
//                     opcode: 00 = A+B, 01 = A-B, 10 = A*B, 11 = unknown
//   done     out  1   one-cycle pulse while the FSM is in DONE
//   result   out  32  IEEE-754 result, held until the next done
//   invalid  out  1   NaN result or unknown opcode, held with result
// ---------------------------------------------------------------------------
module state_machine_fp (
    input  logic        clk,
    input  logic        reset,
    input  logic [65:0] uart_in,
    output logic        done,
    output logic [31:0] result,
    output logic        invalid
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        ALIGN     = 3'd2,
        EXECUTE   = 3'd3,
        NORMALIZE = 3'd4,
        ROUND     = 3'd5,
        DONE      = 3'd6
    } state_t;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    state_t state, state_nxt;

    logic [65:0]        last_word;
    logic               start_pending;
    logic [1:0]         op;
    logic               sa, sb;        // sb already carries the sub flip
    logic [7:0]         ea, eb;        // denormals stored with exponent 1
    logic [23:0]        ma, mb;        // hidden bit included
    logic               spec, spec_inv;
    logic [31:0]        spec_res;
    logic               sgn, sy;
    logic [26:0]        mx, my;        // aligned magnitudes with G/R/S bits
    logic signed [10:0] exp_r;
    logic [49:0]        man;           // leading one of 1.x sits at bit 48

    // ------------------------------------------------------------------
    // Command unpack and special-case resolution (used in LOAD)
    // ------------------------------------------------------------------
    logic [31:0] a_w, b_w;
    logic [1:0]  opc;
    logic        a_nan, a_inf, a_zero, b_nan, b_inf, b_zero, sb_eff;
    logic        spec_c, spec_inv_c;
    logic [31:0] spec_res_c;

    always_comb begin
        a_w    = uart_in[33:2];
        b_w    = uart_in[65:34];
        opc    = uart_in[1:0];
        a_nan  = (&a_w[30:23]) && (|a_w[22:0]);
        a_inf  = (&a_w[30:23]) && !(|a_w[22:0]);
        a_zero = (a_w[30:0] == 31'd0);
        b_nan  = (&b_w[30:23]) && (|b_w[22:0]);
        b_inf  = (&b_w[30:23]) && !(|b_w[22:0]);
        b_zero = (b_w[30:0] == 31'd0);
        sb_eff = b_w[31] ^ (opc == 2'b01);

        spec_c     = 1'b0;
        spec_inv_c = 1'b0;
        spec_res_c = 32'd0;
        if (opc == 2'b11) begin
            spec_c     = 1'b1;
            spec_inv_c = 1'b1;
        end else if (a_nan || b_nan) begin
            spec_c     = 1'b1;
            spec_inv_c = 1'b1;
            spec_res_c = QNAN;
        end else if (opc == 2'b10) begin
            if ((a_inf && b_zero) || (b_inf && a_zero)) begin
                spec_c     = 1'b1;
                spec_inv_c = 1'b1;
                spec_res_c = QNAN;
            end else if (a_inf || b_inf) begin
                spec_c     = 1'b1;
                spec_res_c = {a_w[31] ^ b_w[31], 8'hFF, 23'd0};
            end else if (a_zero || b_zero) begin
                spec_c     = 1'b1;
                spec_res_c = {a_w[31] ^ b_w[31], 31'd0};
            end
        end else begin
            if (a_inf && b_inf && (a_w[31] != sb_eff)) begin
                spec_c     = 1'b1;
                spec_inv_c = 1'b1;
                spec_res_c = QNAN;
            end else if (a_inf) begin
                spec_c     = 1'b1;
                spec_res_c = {a_w[31], 8'hFF, 23'd0};
            end else if (b_inf) begin
                spec_c     = 1'b1;
                spec_res_c = {sb_eff, 8'hFF, 23'd0};
            end else if (a_zero && b_zero) begin
                // -0 survives only when both effective operands are -0
                spec_c     = 1'b1;
                spec_res_c = {a_w[31] & sb_eff, 31'd0};
            end
        end
    end

    // ------------------------------------------------------------------
    // ALIGN: larger magnitude first, smaller shifted right with sticky
    // ------------------------------------------------------------------
    logic        swap;
    logic [7:0]  ex_c, ey_c, d_c;
    logic [23:0] mx_c, my_c;
    logic [53:0] sh_c;
    logic [26:0] my_al;

    always_comb begin
        swap  = ({ea, ma} < {eb, mb});
        ex_c  = swap ? eb : ea;
        ey_c  = swap ? ea : eb;
        mx_c  = swap ? mb : ma;
        my_c  = swap ? ma : mb;
        d_c   = ex_c - ey_c;
        sh_c  = {my_c, 3'b000, 27'd0} >> d_c;
        if (d_c >= 8'd27)
            my_al = {26'd0, |my_c};
        else
            my_al = sh_c[53:27] | {26'd0, |sh_c[26:0]};
    end

    // ------------------------------------------------------------------
    // EXECUTE: magnitude add/sub or 24x24 multiply
    // ------------------------------------------------------------------
    logic [27:0] sum_c;
    logic [47:0] prod_c;

    always_comb begin
        sum_c  = (sgn == sy) ? ({1'b0, mx} + {1'b0, my}) : ({1'b0, mx} - {1'b0, my});
        prod_c = ma * mb;
    end

    // ------------------------------------------------------------------
    // NORMALIZE: carry -> right 1; tiny exponent -> right into denormal
    // range; otherwise left shift, never below exponent 1.
    // ------------------------------------------------------------------
    logic [5:0]         lzc, lsh;
    logic [10:0]        rsh;
    logic signed [10:0] lim, exp_n;
    logic [49:0]        man_n, lowmask;

    always_comb begin
        lzc = 6'd49;
        for (int i = 0; i < 49; i++)
            if (man[i]) lzc = 6'(48 - i);
        rsh     = 11'd1 - exp_r;
        lim     = exp_r - 11'sd1;
        lsh     = 6'd0;
        lowmask = 50'd0;
        man_n   = man;
        exp_n   = exp_r;
        if (exp_r < 11'sd1) begin
            exp_n = 11'sd1;
            if (rsh >= 11'd50) begin
                man_n = {49'd0, |man};
            end else begin
                lowmask = (50'd1 << rsh) - 50'd1;
                man_n   = (man >> rsh) | {49'd0, |(man & lowmask)};
            end
        end else if (man[49]) begin
            man_n = {1'b0, man[49:2], man[1] | man[0]};
            exp_n = exp_r + 11'sd1;
        end else begin
            lsh   = ($signed({5'd0, lzc}) < lim) ? lzc : lim[5:0];
            man_n = man << lsh;
            exp_n = exp_r - $signed({5'd0, lsh});
        end
    end

    // ------------------------------------------------------------------
    // ROUND: nearest-even on man[48:25], guard man[24], sticky below
    // ------------------------------------------------------------------
    logic               g_c, s_c, rup;
    logic [24:0]        m_r;
    logic signed [10:0] exp_f;
    logic [31:0]        rnd_res;

    always_comb begin
        g_c   = man[24];
        s_c   = |man[23:0];
        rup   = g_c & (s_c | man[25]);
        m_r   = {1'b0, man[48:25]} + {24'd0, rup};
        if (m_r[24])
            exp_f = exp_r + 11'sd1;
        else if (m_r[23])
            exp_f = exp_r;
        else
            exp_f = 11'sd0;               // denormal or zero
        if (exp_f >= 11'sd255)
            rnd_res = {sgn, 8'hFF, 23'd0};
        else
            rnd_res = {sgn, exp_f[7:0], m_r[22:0]};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:      state_nxt = (start_pending || (uart_in != last_word)) ? LOAD : IDLE;
            LOAD:      state_nxt = ALIGN;
            ALIGN:     state_nxt = EXECUTE;
            EXECUTE:   state_nxt = NORMALIZE;
            NORMALIZE: state_nxt = ROUND;
            ROUND:     state_nxt = DONE;
            DONE:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            last_word     <= '0;
            start_pending <= 1'b1;
            result        <= '0;
            invalid       <= 1'b0;
            op            <= '0;
            sa            <= 1'b0;
            sb            <= 1'b0;
            ea            <= '0;
            eb            <= '0;
            ma            <= '0;
            mb            <= '0;
            spec          <= 1'b0;
            spec_inv      <= 1'b0;
            spec_res      <= '0;
            sgn           <= 1'b0;
            sy            <= 1'b0;
            mx            <= '0;
            my            <= '0;
            exp_r         <= '0;
            man           <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                LOAD: begin
                    last_word     <= uart_in;
                    start_pending <= 1'b0;
                    op            <= opc;
                    sa            <= a_w[31];
                    sb            <= sb_eff;
                    ea            <= (a_w[30:23] == 8'd0) ? 8'd1 : a_w[30:23];
                    eb            <= (b_w[30:23] == 8'd0) ? 8'd1 : b_w[30:23];
                    ma            <= {a_w[30:23] != 8'd0, a_w[22:0]};
                    mb            <= {b_w[30:23] != 8'd0, b_w[22:0]};
                    spec          <= spec_c;
                    spec_inv      <= spec_inv_c;
                    spec_res      <= spec_res_c;
                end
                ALIGN: begin
                    sgn   <= swap ? sb : sa;
                    sy    <= swap ? sa : sb;
                    mx    <= {mx_c, 3'b000};
                    my    <= my_al;
                    exp_r <= $signed({3'd0, ex_c});
                end
                EXECUTE: begin
                    if (op == 2'b10) begin
                        man   <= {prod_c, 2'b00};
                        exp_r <= $signed({3'd0, ea}) + $signed({3'd0, eb}) - 11'sd127;
                        sgn   <= sa ^ sb;
                    end else begin
                        man <= {sum_c, 22'd0};
                        if (sum_c == 28'd0) sgn <= 1'b0;   // exact cancellation is +0
                    end
                end
                NORMALIZE: begin
                    man   <= man_n;
                    exp_r <= exp_n;
                end
                ROUND: begin
                    result  <= spec ? spec_res : rnd_res;
                    invalid <= spec & spec_inv;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_state_machine_fp.sv
// ---------------------------------------------------------------------------
// tb_state_machine_fp
// Directed bench for state_machine_fp: each step applies one command word in
// IDLE and checks latency, result, invalid and the single-cycle done pulse
// against hand-computed IEEE-754 values.
// ---------------------------------------------------------------------------
module tb_state_machine_fp;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [65:0] uart_in = '0;
    logic        done;
    logic [31:0] result;
    logic        invalid;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    state_machine_fp dut (
        .clk     (clk),
        .reset   (reset),
        .uart_in (uart_in),
        .done    (done),
        .result  (result),
        .invalid (invalid)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a negedge in IDLE right after the command was applied.
    task automatic wait_done(input string tag, input logic [31:0] er, input logic ei);
        int n = 0;
        bit seen = 1'b0;
        while (n < 20 && !seen) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk({tag, "/lat"}, 32'(n), 32'd6);
        chk({tag, "/res"}, result, er);
        chk({tag, "/inv"}, {31'd0, invalid}, {31'd0, ei});
        @(posedge clk);
        @(negedge clk);
        chk({tag, "/pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] opc, input logic [31:0] er, input logic ei);
        uart_in = {b, a, opc};
        wait_done(tag, er, ei);
    endtask

    initial begin
        bit saw;
        // Reset state
        uart_in = {32'h4040_0000, 32'h40A0_0000, 2'b00};
        repeat (2) @(negedge clk);
        chk("rst/state",   32'(dut.state), 32'd0);
        chk("rst/done",    {31'd0, done}, 32'd0);
        chk("rst/result",  result, 32'd0);
        chk("rst/invalid", {31'd0, invalid}, 32'd0);

        // First command after reset starts without a word change
        reset = 1'b1;
        wait_done("add_5_3", 32'h4100_0000, 1'b0);

        // Same word held: no restart, result held
        saw = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1) saw = 1'b1;
        end
        chk("hold/nodone", {31'd0, saw}, 32'd0);
        chk("hold/result", result, 32'h4100_0000);

        // Basic arithmetic
        run("sub_5_3",   32'h40A0_0000, 32'h4040_0000, 2'b01, 32'h4000_0000, 1'b0);
        run("sub_8_3",   32'h4100_0000, 32'h4040_0000, 2'b01, 32'h40A0_0000, 1'b0);
        run("add_8_3",   32'h4100_0000, 32'h4040_0000, 2'b00, 32'h4130_0000, 1'b0);
        run("mul_5_3",   32'h40A0_0000, 32'h4040_0000, 2'b10, 32'h4170_0000, 1'b0);
        run("mul_2_h",   32'h4000_0000, 32'h3F00_0000, 2'b10, 32'h3F80_0000, 1'b0);

        // Infinities
        run("inf+inf",   32'h7F80_0000, 32'h7F80_0000, 2'b00, 32'h7F80_0000, 1'b0);
        run("inf-inf",   32'h7F80_0000, 32'h7F80_0000, 2'b01, 32'h7FC0_0000, 1'b1);
        run("inf+ninf",  32'h7F80_0000, 32'hFF80_0000, 2'b00, 32'h7FC0_0000, 1'b1);
        run("inf-ninf",  32'h7F80_0000, 32'hFF80_0000, 2'b01, 32'h7F80_0000, 1'b0);
        run("zero*inf",  32'h0000_0000, 32'h7F80_0000, 2'b10, 32'h7FC0_0000, 1'b1);

        // Denormals
        run("dn_1+1",    32'h0000_0001, 32'h0000_0001, 2'b00, 32'h0000_0002, 1'b0);
        run("dn_1-1",    32'h0000_0001, 32'h0000_0001, 2'b01, 32'h0000_0000, 1'b0);
        run("dn_1+2",    32'h0000_0001, 32'h0000_0002, 2'b00, 32'h0000_0003, 1'b0);
        run("dn_1-2",    32'h0000_0001, 32'h0000_0002, 2'b01, 32'h8000_0001, 1'b0);

        // Rounding ties and overflow
        run("tie_even",  32'h3F80_0000, 32'h3380_0000, 2'b00, 32'h3F80_0000, 1'b0);
        run("tie_odd",   32'h3F80_0001, 32'h3380_0000, 2'b00, 32'h3F80_0002, 1'b0);
        run("ovf_add",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 2'b00, 32'h7F80_0000, 1'b0);
        run("ovf_mul",   32'h7F00_0000, 32'hFF00_0000, 2'b10, 32'hFF80_0000, 1'b0);

        // NaN operand and unknown opcode
        run("nan_add",   32'h7FC0_0000, 32'h4040_0000, 2'b00, 32'h7FC0_0000, 1'b1);
        run("nan_sub",   32'h7FC0_0000, 32'h4040_0000, 2'b01, 32'h7FC0_0000, 1'b1);
        run("unk_op",    32'h40A0_0000, 32'h4040_0000, 2'b11, 32'h0000_0000, 1'b1);

        // Reset in the middle of EXECUTE
        uart_in = {32'h4040_0000, 32'h40A0_0000, 2'b10};
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mid/state_exec", 32'(dut.state), 32'd3);
        reset = 1'b0;
        #1;
        chk("mid/state", 32'(dut.state), 32'd0);
        chk("mid/done",  {31'd0, done}, 32'd0);
        chk("mid/result", result, 32'd0);
        @(negedge clk);
        // Release: start_pending launches whatever word is present
        uart_in = {32'h4040_0000, 32'h40A0_0000, 2'b00};
        reset = 1'b1;
        wait_done("post_rst", 32'h4100_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
